// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_pkg : shared defaults and bus-slicing helper for pwm_multi       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pwm_pkg;
  localparam int DEFAULT_CHANNELS = 4;
  localparam int DEFAULT_WIDTH    = 27;
  localparam int DEFAULT_DEADTIME = 24;

  function automatic int slice_lo(input int ch, input int width);
    return ch * width;
  endfunction
endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_channel : one PWM channel with double-buffered period/compare    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEADTIME = DEFAULT_DEADTIME
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic [WIDTH-1:0] compare_i,
  input  logic             dir_i,
  output logic             pulse_o,
  output logic             dir_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] count_o
);
  localparam int            DW        = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);

  logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
  logic [WIDTH-1:0] shadow_compare_q, shadow_compare_d;
  logic             shadow_dir_q, shadow_dir_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] active_period_q, active_period_d;
  logic [WIDTH-1:0] active_compare_q, active_compare_d;
  logic             dir_q, dir_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             wrap_q, wrap_d;

  logic             running, at_end, apply;

  always_comb begin
    running = enable_i && (active_period_q != '0);
    at_end  = running && (count_q == active_period_q - WIDTH'(1));
    // Idle channels take a new setting at once; running ones only at the boundary.
    apply   = (load_i || pending_q) && (!running || at_end);

    shadow_period_d  = load_i ? period_i  : shadow_period_q;
    shadow_compare_d = load_i ? compare_i : shadow_compare_q;
    shadow_dir_d     = load_i ? dir_i     : shadow_dir_q;
    pending_d        = apply ? 1'b0 : (load_i || pending_q);

    active_period_d  = apply ? shadow_period_d  : active_period_q;
    active_compare_d = apply ? shadow_compare_d : active_compare_q;
    dir_d            = apply ? shadow_dir_d     : dir_q;

    if (apply && (shadow_dir_d != dir_q)) begin
      dead_d = DEAD_LOAD;
    end else if (dead_q != '0) begin
      dead_d = dead_q - DW'(1);
    end else begin
      dead_d = dead_q;
    end

    count_d = (running && !at_end) ? count_q + WIDTH'(1) : '0;
    wrap_d  = at_end;
    pulse_d = running && (count_q < active_compare_q) && (dead_q == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_period_q  <= '0;
      shadow_compare_q <= '0;
      shadow_dir_q     <= 1'b0;
      pending_q        <= 1'b0;
      active_period_q  <= '0;
      active_compare_q <= '0;
      dir_q            <= 1'b0;
      dead_q           <= '0;
      count_q          <= '0;
      pulse_q          <= 1'b0;
      wrap_q           <= 1'b0;
    end else begin
      shadow_period_q  <= shadow_period_d;
      shadow_compare_q <= shadow_compare_d;
      shadow_dir_q     <= shadow_dir_d;
      pending_q        <= pending_d;
      active_period_q  <= active_period_d;
      active_compare_q <= active_compare_d;
      dir_q            <= dir_d;
      dead_q           <= dead_d;
      count_q          <= count_d;
      pulse_q          <= pulse_d;
      wrap_q           <= wrap_d;
    end
  end

  assign pulse_o = pulse_q;
  assign dir_o   = dir_q;
  assign wrap_o  = wrap_q;
  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_multi : CHANNELS independent PWM/direction motor-drive channels  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEADTIME = DEFAULT_DEADTIME
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] period_in,
  input  logic [CHANNELS*WIDTH-1:0] compare_in,
  input  logic [CHANNELS-1:0]       dir_in,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       wrap,
  output logic [CHANNELS*WIDTH-1:0] count
);
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam int LO = slice_lo(gi, WIDTH);

    pwm_channel #(
      .WIDTH    (WIDTH),
      .DEADTIME (DEADTIME)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable_i  (enable[gi]),
      .load_i    (load[gi]),
      .period_i  (period_in[LO +: WIDTH]),
      .compare_i (compare_in[LO +: WIDTH]),
      .dir_i     (dir_in[gi]),
      .pulse_o   (pulse[gi]),
      .dir_o     (dir[gi]),
      .wrap_o    (wrap[gi]),
      .count_o   (count[LO +: WIDTH])
    );
  end
endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_multi : directed + randomized bench for pwm_multi             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pwm_multi;
  localparam int CH = 4;
  localparam int W  = 27;
  localparam int DT = 24;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [CH-1:0]   en, ld, dir_r;
  logic [CH*W-1:0] per_in, cmp_in;
  logic [CH-1:0]   pulse, dir, wrap;
  logic [CH*W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_multi #(.CHANNELS(CH), .WIDTH(W), .DEADTIME(DT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (en),
    .load       (ld),
    .period_in  (per_in),
    .compare_in (cmp_in),
    .dir_in     (dir_r),
    .pulse      (pulse),
    .dir        (dir),
    .wrap       (wrap),
    .count      (count)
  );

  initial forever #5 clock = ~clock;

  // Reference: the period in force, the position within it, the guard time left,
  // and the most recent not-yet-applied request.
  typedef struct packed {
    int per; int cmp; int pos; int guard; int req_per; int req_cmp;
    bit req_dir; bit has_req; bit dir; bit pulse; bit wrap;
  } chan_t;

  chan_t m [CH];

  function automatic chan_t step(chan_t s, bit e, bit l, int p, int cp, bit d);
    chan_t n;
    bit    run, last;
    n    = s;
    run  = e && (s.per != 0);
    last = run && (s.pos == s.per - 1);
    n.pulse = run && (s.pos < s.cmp) && (s.guard == 0);
    n.wrap  = last;
    n.pos   = (run && !last) ? s.pos + 1 : 0;
    n.guard = (s.guard > 0) ? s.guard - 1 : 0;
    if (l) begin
      n.req_per = p; n.req_cmp = cp; n.req_dir = d; n.has_req = 1'b1;
    end
    if (n.has_req && (!run || last)) begin
      if (n.req_dir != s.dir) n.guard = DT;
      n.per = n.req_per; n.cmp = n.req_cmp; n.dir = n.req_dir; n.has_req = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    for (int c = 0; c < CH; c++) begin
      if (!reset_n) m[c] <= '0;
      else m[c] <= step(m[c], en[c], ld[c], int'(per_in[c*W +: W]),
                        int'(cmp_in[c*W +: W]), dir_r[c]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    @(negedge clock);
    forever begin
      for (int c = 0; c < CH; c++)
        chk($sformatf("model_ch%0d", c), {2'b00, pulse[c], dir[c], wrap[c], count[c*W +: W]},
            {2'b00, m[c].pulse, m[c].dir, m[c].wrap, W'(m[c].pos)});
      @(negedge clock);
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_chan(input int c, input int p, input int cp, input bit d);
    per_in[c*W +: W] = W'(p);
    cmp_in[c*W +: W] = W'(cp);
    dir_r[c]         = d;
    ld[c]            = 1'b1;
  endtask

  initial begin
    logic [19:0] pv, wv;
    int          n, sum;
    reset_n = 1'b0; en = '0; ld = '0; dir_r = '0; per_in = '0; cmp_in = '0;
    repeat (3) tick();
    chk("reset_state", 32'(|{pulse, dir, wrap, count}), 32'd0);
    reset_n = 1'b1;
    tick();

    // ch0: period 10, compare 3
    set_chan(0, 10, 3, 1'b0); en[0] = 1'b1;
    tick(); ld = '0;
    for (int i = 0; i < 20; i++) begin
      pv[19-i] = pulse[0];
      wv[19-i] = wrap[0];
      chk($sformatf("t1_count_%0d", i), 32'(count[0 +: W]), 32'(i % 10));
      tick();
    end
    chk("t1_pulse_pattern", 32'(pv), 32'h701C0);
    chk("t1_wrap_pattern",  32'(wv), 32'h00200);
    chk("t1_dir", 32'(dir[0]), 32'd0);

    // ch0: compare change mid-period takes effect after the wrap
    n = 0;
    while (count[0 +: W] != W'(4) && n < 20) begin tick(); n++; end
    chk("t2_reach_count4", 32'(count[0 +: W]), 32'd4);
    set_chan(0, 10, 7, 1'b0); tick(); ld = '0;
    n = 0;
    while (!wrap[0] && n < 30) begin tick(); n++; end
    chk("t2_wrap_seen", 32'(wrap[0]), 32'd1);
    sum = 0;
    for (int i = 0; i < 10; i++) begin tick(); sum += int'(pulse[0]); end
    chk("t2_high_clocks", 32'(sum), 32'd7);

    // ch1: direction flip with dead time
    set_chan(1, 100, 50, 1'b0); en[1] = 1'b1; tick(); ld = '0;
    repeat (30) tick();
    set_chan(1, 100, 50, 1'b1); tick(); ld = '0;
    n = 0;
    while (!wrap[1] && n < 200) begin tick(); n++; end
    chk("t3_wrap_seen", 32'(wrap[1]), 32'd1);
    chk("t3_dir_at_wrap", 32'(dir[1]), 32'd1);
    sum = 0;
    for (int i = 0; i < 100; i++) begin tick(); sum += int'(pulse[1]); end
    chk("t3_high_clocks", 32'(sum), 32'd26);

    // ch3: compare >= period then compare 0
    set_chan(3, 10, 12, 1'b0); en[3] = 1'b1; tick(); ld = '0;
    repeat (3) tick();
    sum = 0;
    for (int i = 0; i < 25; i++) begin sum += int'(!pulse[3]); tick(); end
    chk("t4_full_on_lows", 32'(sum), 32'd0);
    set_chan(3, 10, 0, 1'b0); tick(); ld = '0;
    n = 0;
    while (!wrap[3] && n < 30) begin tick(); n++; end
    chk("t4_wrap_seen", 32'(wrap[3]), 32'd1);
    repeat (2) tick();
    sum = 0;
    for (int i = 0; i < 25; i++) begin sum += int'(pulse[3]); tick(); end
    chk("t4_full_off_highs", 32'(sum), 32'd0);

    // ch2: period 0 holds idle, then period 5
    en[2] = 1'b1;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); sum += int'(|{pulse[2], wrap[2], count[2*W +: W]});
    end
    chk("t5_idle_activity", 32'(sum), 32'd0);
    set_chan(2, 5, 2, 1'b0); tick(); ld = '0;
    n = 0;
    while (!wrap[2] && n < 20) begin tick(); n++; end
    chk("t5_wrap_latency", 32'(n), 32'd5);

    // asynchronous reset with pending loads on every channel
    reset_n = 1'b0; en = '0; repeat (2) tick(); reset_n = 1'b1;
    for (int c = 0; c < CH; c++) set_chan(c, 50, 25, 1'b0);
    en = '1; tick(); ld = '0;
    repeat (5) tick();
    for (int c = 0; c < CH; c++) set_chan(c, 7, 3, 1'b1);
    tick(); ld = '0;
    repeat (2) tick();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk("t6_async_zero", 32'(|{pulse, dir, wrap, count}), 32'd0);
    @(negedge clock);
    tick();
    reset_n = 1'b1;
    sum = 0;
    for (int i = 0; i < 10; i++) begin tick(); sum += int'(|{dir, wrap, count}); end
    chk("t6_pending_dropped", 32'(sum), 32'd0);

    // randomized traffic against the reference
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        ld[c] = 1'b0;
        if ($urandom_range(0, 7) == 0)
          set_chan(c, int'($urandom_range(0, 20)), int'($urandom_range(0, 24)),
                   1'($urandom_range(0, 1)));
        if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
      end
      tick();
    end
    ld = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
